fir_mc: RTL and testbench

- Parametrised successor to the single-channel bit-serial FIR: time-multiplexed, multi-channel, odd-tap linear-phase filter with one shared coefficient set and a separate delay line per channel.
- Bit-serial multiply-accumulate: one sample bit per coefficient per clock. Symmetric or anti-symmetric mode is selected per sample.
- Adds a valid/ready input handshake, a channel tag, a delay-line flush, and saturating output with a flag.
- Sits between the sample front-end and the DAC/output formatter.

---
 rtl/fir_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_fir_mc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mc.sv
// fir_mc: time-multiplexed multi-channel bit-serial linear-phase FIR.
// One shared coefficient set (loaded serially), one delay line per channel,
// one sample bit per coefficient per clock, saturating unsigned output.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       sample handshake (in_ready is combinational)
//   in_ch, x, sym_coeffs    channel tag, sample, symmetric(1)/anti-symmetric(0)
//   coeff_load, coeff_in    serial coefficient shift enable and data bit
//   flush                   clear every delay line (IDLE only)
//   out_valid, out_ch, y, sat  one-cycle result pulse, channel, result, clamp flag
module fir_mc #(
    parameter int unsigned DataWidth  = 12,
    parameter int unsigned CoeffWidth = 12,
    parameter int unsigned NTaps      = 9,
    parameter int unsigned NChannels  = 2,
    localparam int unsigned ChW = (NChannels > 1) ? $clog2(NChannels) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ChW-1:0]       in_ch,
    input  logic [DataWidth-1:0] x,
    input  logic                 sym_coeffs,
    input  logic                 coeff_load,
    input  logic                 coeff_in,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [ChW-1:0]       out_ch,
    output logic [DataWidth-1:0] y,
    output logic                 sat
);

    localparam int unsigned NCoeffs = (NTaps + 1) / 2;
    localparam int unsigned AccW    = DataWidth + CoeffWidth + $clog2(NTaps) + 1;
    localparam int unsigned CW      = NCoeffs * CoeffWidth;
    localparam int unsigned JW      = (NCoeffs > 1) ? $clog2(NCoeffs) : 1;
    localparam int unsigned BW      = (DataWidth > 1) ? $clog2(DataWidth) : 1;

    localparam logic signed [AccW-1:0] C_OFS  = AccW'(1) << (DataWidth - 1);
    localparam logic signed [AccW-1:0] C_YMAX = (AccW'(1) << DataWidth) - AccW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_MAC  = 2'd2;

    if ((NTaps % 2) == 0 || NTaps < 3) begin : g_bad_ntaps
        $fatal(1, "fir_mc: NTaps must be odd and >= 3");
    end
    if (NChannels < 1) begin : g_bad_nch
        $fatal(1, "fir_mc: NChannels must be >= 1");
    end

    logic [1:0]                                   r_state;
    logic [1:0]                                   w_state_nxt;
    logic [CW-1:0]                                r_coef;
    logic [NChannels-1:0][NTaps-1:0][DataWidth-1:0] r_line;
    logic [ChW-1:0]                               r_ch;
    logic                                         r_sym;
    logic signed [AccW-1:0]                       r_acc;
    logic [JW-1:0]                                r_j;
    logic [BW-1:0]                                r_b;

    logic                   w_idle;
    logic                   w_ch_ok;
    logic                   w_accept;
    logic                   w_flush;
    logic                   w_last;
    logic                   w_centre;
    logic [DataWidth-1:0]   w_near;
    logic [DataWidth-1:0]   w_far;
    logic signed [CoeffWidth-1:0] w_coef;
    logic signed [AccW-1:0] w_cext;
    logic signed [AccW-1:0] w_term;
    logic signed [AccW-1:0] w_acc_nxt;
    logic signed [AccW-1:0] w_v;
    logic [DataWidth-1:0]   w_y;
    logic                   w_sat;

    assign w_idle   = (r_state == S_IDLE);
    assign in_ready = rst_n && w_idle && !coeff_load && !flush;
    assign w_ch_ok  = ({1'b0, in_ch} < (ChW + 1)'(NChannels));
    assign w_accept = in_valid && in_ready;
    assign w_flush  = w_idle && !coeff_load && flush;
    assign w_centre = (r_j == JW'(NCoeffs - 1));
    assign w_last   = w_centre && (r_b == BW'(DataWidth - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; coeff_load outranks flush, which outranks a sample
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (coeff_load) begin
                    w_state_nxt = S_LOAD;
                end else if (w_accept && w_ch_ok) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_LOAD: begin
                if (!coeff_load) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MAC: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Select the tap pair and coefficient for the current index j
    always_comb begin
        w_near = '0;
        w_far  = '0;
        w_coef = '0;
        for (int c = 0; c < NChannels; c++) begin
            for (int k = 0; k < NCoeffs; k++) begin
                if (r_ch == ChW'(c) && r_j == JW'(k)) begin
                    w_near = r_line[c][k];
                    w_far  = r_line[c][NTaps-1-k];
                end
            end
        end
        for (int k = 0; k < NCoeffs; k++) begin
            if (r_j == JW'(k)) begin
                w_coef = r_coef[k*CoeffWidth +: CoeffWidth];
            end
        end
    end

    // One partial product: (near +/- far) bit b times c[j], weighted by 2^b
    always_comb begin
        w_cext = AccW'(w_coef) <<< r_b;
        w_term = '0;
        if (w_near[r_b]) begin
            w_term = w_cext;
        end
        if (!w_centre && w_far[r_b]) begin
            w_term = r_sym ? (w_term + w_cext) : (w_term - w_cext);
        end
        w_acc_nxt = r_acc + w_term;
    end

    // Rescale, re-bias to unsigned and clamp the final sum
    always_comb begin
        w_v   = (w_acc_nxt >>> (CoeffWidth - 1)) + C_OFS;
        w_y   = w_v[DataWidth-1:0];
        w_sat = 1'b0;
        if (w_v[AccW-1]) begin
            w_y   = '0;
            w_sat = 1'b1;
        end else if (w_v > C_YMAX) begin
            w_y   = '1;
            w_sat = 1'b1;
        end
    end

    // Serial coefficient chain: c[0] LSB at bit 0, c[NCoeffs-1] MSB at the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coef <= '0;
        end else if (r_state != S_MAC && coeff_load) begin
            r_coef <= {r_coef[CW-2:0], coeff_in};
        end
    end

    // Delay lines: tap 0 is the newest sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= '0;
        end else if (w_flush) begin
            r_line <= '0;
        end else if (w_accept && w_ch_ok) begin
            for (int c = 0; c < NChannels; c++) begin
                if (in_ch == ChW'(c)) begin
                    r_line[c] <= {r_line[c][NTaps-2:0], x};
                end
            end
        end
    end

    // MAC sequencing: bit index b inner, coefficient index j outer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch  <= '0;
            r_sym <= 1'b0;
            r_acc <= '0;
            r_j   <= '0;
            r_b   <= '0;
        end else if (w_accept && w_ch_ok) begin
            r_ch  <= in_ch;
            r_sym <= sym_coeffs;
            r_acc <= '0;
            r_j   <= '0;
            r_b   <= '0;
        end else if (r_state == S_MAC) begin
            r_acc <= w_acc_nxt;
            if (r_b == BW'(DataWidth - 1)) begin
                r_b <= '0;
                r_j <= r_j + JW'(1);
            end else begin
                r_b <= r_b + BW'(1);
            end
        end
    end

    // Result registers; y/out_ch/sat hold until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            y         <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= (r_state == S_MAC) && w_last;
            if ((r_state == S_MAC) && w_last) begin
                out_ch <= r_ch;
                y      <= w_y;
                sat    <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_fir_mc.sv
// Scoreboard bench for fir_mc (3 channels so that in_ch=3 is out of range).
module tb_fir_mc;

    localparam int unsigned DW  = 12;
    localparam int unsigned CWD = 12;
    localparam int unsigned NT  = 9;
    localparam int unsigned NCH = 3;
    localparam int unsigned CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [CHW-1:0] in_ch = '0;
    logic [DW-1:0]  x = '0;
    logic           sym_coeffs = 1'b0;
    logic           coeff_load = 1'b0;
    logic           coeff_in = 1'b0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic [CHW-1:0] out_ch;
    logic [DW-1:0]  y;
    logic           sat;

    int n_cmp = 0;
    int n_bad = 0;

    // {ch, y, sat}
    logic [CHW+DW:0] sb_q[$];
    logic [CHW+DW:0] mon_act;
    logic [CHW+DW:0] mon_exp;

    always #5 clk = ~clk;

    fir_mc #(
        .DataWidth (DW),
        .CoeffWidth(CWD),
        .NTaps     (NT),
        .NChannels (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .x         (x),
        .sym_coeffs(sym_coeffs),
        .coeff_load(coeff_load),
        .coeff_in  (coeff_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .y         (y),
        .sat       (sat)
    );

    // Monitor: every out_valid pops one expected result
    always @(negedge clk) begin
        if (out_valid) begin
            mon_act = {out_ch, y, sat};
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got ch=%0d y=%0d sat=%0d, required no out_valid",
                         out_ch, y, sat);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_bad++;
                    $display("FAIL result: got ch=%0d y=%0d sat=%0d, required ch=%0d y=%0d sat=%0d",
                             out_ch, y, sat, mon_exp[CHW+DW:DW+1], mon_exp[DW:1], mon_exp[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Offer one sample, push its expected result, then measure handshake timing
    task automatic send(input logic [CHW-1:0] ch, input logic [DW-1:0] xv, input logic sy,
                        input logic [DW-1:0] ey, input logic es);
        bit ok;
        bit valid_ch;
        int lo;
        valid_ch   = (ch < NCH);
        in_ch      = ch;
        x          = xv;
        sym_coeffs = sy;
        in_valid   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 300 cycles, required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (valid_ch) sb_q.push_back({ch, ey, es});
        #1;
        in_valid = 1'b0;
        lo = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) break;
            lo++;
        end
        chk("ready_low_cycles", 32'(lo), valid_ch ? 32'd60 : 32'd0);
        chk("out_valid_latency", 32'(out_valid), valid_ch ? 32'd1 : 32'd0);
    endtask

    // Stream c[4] MSB first down to c[0] LSB last, preceded by one don't-care bit
    task automatic load_coeffs(input logic [CWD-1:0] c0, input logic [CWD-1:0] c1,
                               input logic [CWD-1:0] c2, input logic [CWD-1:0] c3,
                               input logic [CWD-1:0] c4);
        logic [5*CWD-1:0] bits;
        bits       = {c4, c3, c2, c1, c0};
        coeff_load = 1'b1;
        coeff_in   = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_in_load", 32'(in_ready), 32'd0);
        for (int i = 5*CWD-1; i >= 0; i--) begin
            coeff_in = bits[i];
            @(negedge clk);
        end
        coeff_load = 1'b0;
        coeff_in   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        #1;
        chk("ready_in_flush", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Sample held while coeff_load is raised: LOAD wins, sample waits
        in_ch = 0; x = 12'd2048; sym_coeffs = 1'b1; in_valid = 1'b1;
        load_coeffs(12'd1024, 12'd0, 12'd0, 12'd0, 12'd0);

        // Preload ch0 so that a missing flush would show later
        send(2'd0, 12'd2048, 1'b1, 12'd3072, 1'b0);
        for (int i = 0; i < 4; i++) send(2'd0, 12'd0, 1'b1, 12'd2048, 1'b0);
        do_flush();

        // Symmetric impulse
        send(2'd0, 12'd2048, 1'b1, 12'd3072, 1'b0);
        for (int i = 0; i < 7; i++) send(2'd0, 12'd0, 1'b1, 12'd2048, 1'b0);
        send(2'd0, 12'd0, 1'b1, 12'd3072, 1'b0);
        do_flush();

        // Anti-symmetric impulse
        send(2'd0, 12'd2048, 1'b0, 12'd3072, 1'b0);
        for (int i = 0; i < 7; i++) send(2'd0, 12'd0, 1'b0, 12'd2048, 1'b0);
        send(2'd0, 12'd0, 1'b0, 12'd1024, 1'b0);
        do_flush();

        // Channel isolation plus an out-of-range channel
        send(2'd0, 12'd2048, 1'b1, 12'd3072, 1'b0);
        send(2'd1, 12'd0,    1'b1, 12'd2048, 1'b0);
        send(2'd3, 12'd2048, 1'b1, 12'd0,    1'b0);
        send(2'd0, 12'd0,    1'b1, 12'd2048, 1'b0);
        send(2'd1, 12'd0,    1'b1, 12'd2048, 1'b0);
        send(2'd0, 12'd0,    1'b1, 12'd2048, 1'b0);
        send(2'd1, 12'd0,    1'b1, 12'd2048, 1'b0);

        // Negative saturation
        load_coeffs(12'h800, 12'd0, 12'd0, 12'd0, 12'd0);
        do_flush();
        send(2'd0, 12'd4095, 1'b0, 12'd0, 1'b1);

        // Positive saturation on ch1
        load_coeffs(12'd2047, 12'd2047, 12'd2047, 12'd2047, 12'd2047);
        do_flush();
        for (int i = 0; i < 9; i++) send(2'd1, 12'd4095, 1'b1, 12'd4095, 1'b1);

        // Reset in the middle of a MAC
        in_ch = 0; x = 12'd100; sym_coeffs = 1'b1; in_valid = 1'b1;
        #1;
        chk("ready_before_abort", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_y", 32'(y), 32'd0);
        chk("abort_sat", 32'(sat), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 32'(in_ready), 32'd1);
        chk("no_valid_after_abort", 32'(out_valid), 32'd0);
        repeat (70) @(negedge clk);

        // Coefficients were cleared by reset
        send(2'd0, 12'd100, 1'b1, 12'd2048, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
